muldiv_sched: RTL and testbench

- Execute-stage sequencer for the multi-cycle units next to the ALU: a fixed-latency pipelined multiplier and the iterative radix-2 divider.
- Launches MULT/MULTU/DIV/DIVU, drives the pipeline stall, and cancels work on flush.
- Owns the architectural HI/LO register pair, including single-cycle MTHI/MTLO writes.
- Sits between the ALU decode controls and the hazard unit; HI/LO read data feeds MFHI/MFLO muxing.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_hilo_reg.sv | 24 ++
 rtl/muldiv_sched.sv | 155 +++++++++++++++
 tb/tb_muldiv_sched.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings, widths and FSM states for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  localparam int DATA_W = 32;
  localparam int PROD_W = 64;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

endpackage

// File: rtl/muldiv_hilo_reg.sv
// Architectural HI/LO pair; HI takes the upper half of the write port, LO the lower half.
module muldiv_hilo_reg
  import muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [PROD_W-1:0] wdata,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (hi_we) hi <= wdata[PROD_W-1 -: DATA_W];
      if (lo_we) lo <= wdata[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/muldiv_sched.sv
// Execute-stage sequencer for the pipelined multiplier and iterative divider;
// owns HI/LO, drives the pipeline stall and aborts work on flush.
module muldiv_sched
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT     = 3,
  parameter int DIV_TIMEOUT = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              stall_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [DATA_W-1:0] mul_a,
  output logic [DATA_W-1:0] mul_b,
  output logic              mul_signed,
  input  logic [PROD_W-1:0] mul_p,
  output logic              div_start,
  output logic              div_signed,
  output logic              div_annul,
  output logic [DATA_W-1:0] div_a,
  output logic [DATA_W-1:0] div_b,
  input  logic              div_ready,
  input  logic [PROD_W-1:0] div_result,
  output logic              err_o
);

  localparam int CNT_W = 3;
  localparam int WD_W  = $clog2(DIV_TIMEOUT + 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [WD_W-1:0]   wd;

  logic              launch_ok;
  logic              mul_go;
  logic              div_op;
  logic              div_go;
  logic              mul_fin;
  logic              div_fin;
  logic              hi_we;
  logic              lo_we;
  logic [PROD_W-1:0] wdata;

  assign launch_ok = (state == IDLE) && op_valid && !flush;
  assign mul_go    = launch_ok && (op == OP_MULT || op == OP_MULTU);
  assign div_op    = launch_ok && (op == OP_DIV || op == OP_DIVU);
  assign div_go    = div_op && (b != '0);
  assign mul_fin   = (state == MUL) && (cnt == '0) && !flush;
  assign div_fin   = (state == DIV) && div_ready && !flush;

  // The launch cycle must already stall so the instruction stays in E.
  assign stall_o = (state == MUL) || (state == DIV) || mul_go || div_go;

  assign hi_we = mul_fin || div_fin || (launch_ok && op == OP_MTHI);
  assign lo_we = mul_fin || div_fin || (launch_ok && op == OP_MTLO);

  always_comb begin
    wdata = {a, a};
    if (state == MUL)      wdata = mul_p;
    else if (state == DIV) wdata = div_result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wd         <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_signed <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
      div_signed <= 1'b0;
      div_start  <= 1'b0;
      div_annul  <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      div_annul <= 1'b0;
      case (state)
        IDLE: begin
          if (mul_go) begin
            mul_a      <= a;
            mul_b      <= b;
            mul_signed <= (op == OP_MULT);
            cnt        <= CNT_W'(MUL_LAT - 1);
            state      <= MUL;
          end else if (div_go) begin
            div_a      <= a;
            div_b      <= b;
            div_signed <= (op == OP_DIV);
            wd         <= '0;
            div_start  <= 1'b1;
            state      <= DIV;
          end else if (div_op) begin
            done_o <= 1'b1;
          end
        end
        MUL: begin
          if (flush) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            done_o <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DIV: begin
          // Flush and timeout both abort the divider without touching HI/LO.
          if (flush) begin
            div_start <= 1'b0;
            div_annul <= 1'b1;
            state     <= IDLE;
          end else if (div_ready) begin
            div_start <= 1'b0;
            done_o    <= 1'b1;
            state     <= DONE;
          end else if (wd == WD_W'(DIV_TIMEOUT - 1)) begin
            div_start <= 1'b0;
            div_annul <= 1'b1;
            err_o     <= 1'b1;
            state     <= DONE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        DONE: begin
          if (flush || !ex_hold) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  muldiv_hilo_reg u_hilo (
    .clk   (clk),
    .rst   (rst),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .hi    (hi_o),
    .lo    (lo_o)
  );

endmodule

// File: tb/tb_muldiv_sched.sv
// Scoreboard bench for muldiv_sched with behavioural multiplier and divider models.
module tb_muldiv_sched;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        ex_hold = 1'b0;
  logic        stall_o, done_o, err_o;
  logic [31:0] hi_o, lo_o;
  logic [31:0] mul_a, mul_b, div_a, div_b;
  logic        mul_signed, div_start, div_signed, div_annul, div_ready;
  logic [63:0] mul_p, div_result;

  int checks = 0;
  int fails = 0;
  int stall_cnt = 0;
  int start_cnt = 0;
  int annul_cnt = 0;
  int done_cnt = 0;
  int ready_after = 33;
  int dcnt = 0;
  logic [63:0] exp_q[$];

  muldiv_sched #(.MUL_LAT(3), .DIV_TIMEOUT(40)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .a(a), .b(b),
    .flush(flush), .ex_hold(ex_hold), .stall_o(stall_o), .done_o(done_o),
    .hi_o(hi_o), .lo_o(lo_o), .mul_a(mul_a), .mul_b(mul_b),
    .mul_signed(mul_signed), .mul_p(mul_p), .div_start(div_start),
    .div_signed(div_signed), .div_annul(div_annul), .div_a(div_a),
    .div_b(div_b), .div_ready(div_ready), .div_result(div_result),
    .err_o(err_o)
  );

  initial forever #5 clk = ~clk;

  // Multiplier: combinational product followed by two flops, valid three cycles after launch.
  logic [63:0] p0, pipe1, pipe2;
  always_comb begin
    p0 = '0;
    if (mul_signed) p0 = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
    else            p0 = {32'b0, mul_a} * {32'b0, mul_b};
  end
  always @(posedge clk) begin
    pipe1 <= p0;
    pipe2 <= pipe1;
  end
  assign mul_p = pipe2;

  // Divider: answers ready_after cycles into a div_start level.
  logic [31:0] dq, dr;
  always_comb begin
    dq = '0;
    dr = '0;
    if (div_b != '0) begin
      if (div_signed) begin
        dq = $signed(div_a) / $signed(div_b);
        dr = $signed(div_a) % $signed(div_b);
      end else begin
        dq = div_a / div_b;
        dr = div_a % div_b;
      end
    end
  end
  assign div_result = {dr, dq};
  always @(posedge clk) begin
    if (rst || !div_start) dcnt <= 0;
    else                   dcnt <= dcnt + 1;
  end
  assign div_ready = div_start && (dcnt == ready_after - 1);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitorLoop();
    logic [63:0] e;
    forever begin
      @(negedge clk);
      stall_cnt += int'(stall_o);
      start_cnt += int'(div_start);
      annul_cnt += int'(div_annul);
      if (done_o) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_done: done_o=1 with hi=0x%0h lo=0x%0h, expected no pulse", hi_o, lo_o);
        end else begin
          e = exp_q.pop_front();
          checkOutput("done_hilo", {hi_o, lo_o}, e);
        end
      end
    end
  endtask

  task automatic waitAccept(input int s0, output int stalls);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = !stall_o && !ex_hold;
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("[TB] FAIL accept: instruction still stalled after 200 cycles, expected acceptance");
    end
    @(posedge clk); #1;
    stalls = stall_cnt - s0;
  endtask

  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                               output int stalls);
    int s0;
    op_valid = 1'b1;
    op = o;
    a = av;
    b = bv;
    s0 = stall_cnt;
    waitAccept(s0, stalls);
  endtask

  task automatic idle(input int n);
    op_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int st, d0, s0, a0, n0;
    bit seen;
    fork
      monitorLoop();
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_hi", hi_o, 0);
    checkOutput("rst_lo", lo_o, 0);
    checkOutput("rst_stall", stall_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_div_start", div_start, 0);
    checkOutput("rst_div_annul", div_annul, 0);
    checkOutput("rst_err", err_o, 0);
    checkOutput("rst_mul_a", mul_a, 0);
    checkOutput("rst_div_b", div_b, 0);
    @(posedge clk); #1;

    // MULT -2 * 3
    d0 = done_cnt;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFA);
    applyStimulus(OP_MULT, 32'hFFFF_FFFE, 32'd3, st);
    idle(3);
    checkOutput("mult_stall_cycles", st, 4);
    checkOutput("mult_done_count", done_cnt - d0, 1);

    // DIVU 100 / 7 with divider answering after 33 cycles
    d0 = done_cnt;
    s0 = start_cnt;
    exp_q.push_back({32'd2, 32'd14});
    applyStimulus(OP_DIVU, 32'd100, 32'd7, st);
    idle(2);
    checkOutput("divu_stall_cycles", st, 34);
    checkOutput("divu_start_cycles", start_cnt - s0, 33);
    checkOutput("divu_done_count", done_cnt - d0, 1);

    // DIV by zero
    d0 = done_cnt;
    s0 = start_cnt;
    exp_q.push_back({32'd2, 32'd14});
    applyStimulus(OP_DIV, 32'h8000_0000, 32'd0, st);
    idle(3);
    checkOutput("div0_stall_cycles", st, 0);
    checkOutput("div0_start_cycles", start_cnt - s0, 0);
    checkOutput("div0_done_count", done_cnt - d0, 1);

    // MTHI then MTLO back to back
    s0 = stall_cnt;
    applyStimulus(OP_MTHI, 32'h1234, 32'd0, st);
    applyStimulus(OP_MTLO, 32'h5678, 32'd0, st);
    idle(1);
    checkOutput("mt_hi", hi_o, 32'h1234);
    checkOutput("mt_lo", lo_o, 32'h5678);
    checkOutput("mt_stall_cycles", stall_cnt - s0, 0);

    // DIV flushed on its tenth cycle, MULTU issued right behind it
    d0 = done_cnt;
    a0 = annul_cnt;
    op_valid = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd5;
    repeat (10) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    op = OP_MULTU; a = 32'hFFFF_FFFF; b = 32'd2;
    exp_q.push_back(64'h0000_0001_FFFF_FFFE);
    s0 = stall_cnt;
    @(negedge clk);
    checkOutput("flush_hilo_kept", {hi_o, lo_o}, {32'h1234, 32'h5678});
    checkOutput("flush_div_annul", div_annul, 1);
    checkOutput("flush_div_start", div_start, 0);
    waitAccept(s0, st);
    idle(2);
    checkOutput("multu_stall_cycles", st, 4);
    checkOutput("flush_annul_count", annul_cnt - a0, 1);
    checkOutput("flush_done_count", done_cnt - d0, 1);

    // MULT finishing under a 3-cycle ex_hold
    d0 = done_cnt;
    s0 = stall_cnt;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFDD);
    op_valid = 1'b1; op = OP_MULT; a = 32'd7; b = 32'hFFFF_FFFB; ex_hold = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = !stall_o;
    end
    checkOutput("hold_stall_released", seen, 1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("hold_stall_low", stall_o, 0);
    end
    @(posedge clk); #1;
    ex_hold = 1'b0;
    @(posedge clk); #1;
    checkOutput("hold_stall_cycles", stall_cnt - s0, 4);
    applyStimulus(OP_MTLO, 32'hABCD, 32'd0, st);
    idle(2);
    checkOutput("hold_done_count", done_cnt - d0, 1);
    checkOutput("hold_hi", hi_o, 32'hFFFF_FFFF);
    checkOutput("hold_lo_after_mtlo", lo_o, 32'hABCD);

    // Divider never answers: watchdog fires
    ready_after = 1000;
    d0 = done_cnt;
    a0 = annul_cnt;
    s0 = start_cnt;
    applyStimulus(OP_DIVU, 32'd10, 32'd3, st);
    idle(2);
    checkOutput("timeout_stall_cycles", st, 41);
    checkOutput("timeout_start_cycles", start_cnt - s0, 40);
    checkOutput("timeout_annul_count", annul_cnt - a0, 1);
    checkOutput("timeout_err", err_o, 1);
    checkOutput("timeout_done_count", done_cnt - d0, 0);
    checkOutput("timeout_hilo_kept", {hi_o, lo_o}, {32'hFFFF_FFFF, 32'hABCD});

    // Reset in the middle of a divide
    ready_after = 33;
    n0 = done_cnt;
    op_valid = 1'b1; op = OP_DIVU; a = 32'd50; b = 32'd5;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    op_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_hi", hi_o, 0);
    checkOutput("midrst_lo", lo_o, 0);
    checkOutput("midrst_err", err_o, 0);
    checkOutput("midrst_stall", stall_o, 0);
    checkOutput("midrst_div_start", div_start, 0);
    idle(40);
    checkOutput("midrst_done_count", done_cnt - n0, 0);
    checkOutput("pending_expectations", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
